// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the prefetching instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    IFQ_IDLE    = 2'd0,
    IFQ_WAIT    = 2'd1,
    IFQ_DISCARD = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Instruction memory req/ack bus; master is the fetch unit, slave is the memory.
interface inst_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// ifq_fifo: DEPTH x {pc, inst} circular buffer with push, pop and a flush that wins over both.
module ifq_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  ifq_entry_t    wdata,
  output ifq_entry_t    rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  ifq_entry_t    store [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) store[tail] <= wdata;
  end

  assign rdata = store[head];
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetching fetch stage: one outstanding req/ack fetch, results queued for IF/ID.
// Optional IFQ_BYPASS_EN forwards ack data straight to I_* when the queue is empty.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       Clrn,
  inst_fetch_queue_if.master         mem,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                I_PC,
  output logic [31:0]                I_PC4,
  output logic [31:0]                I_Inst,
  output logic                       I_Valid
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

  ifq_state_e  state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] redir_pc, redir_pc_n;
  logic        push, pop, room, bypass_take;
  logic [CW-1:0] count;
  logic [CW:0]   count_n;
  logic        empty;
  ifq_entry_t  head, wentry;

  assign mem.mem_req  = (state != IFQ_IDLE);
  assign mem.mem_addr = fetch_pc;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass      = empty && (state == IFQ_WAIT) && mem.mem_ack && !redirect;
  assign bypass_take = bypass && !stall;
`else
  assign bypass_take = 1'b0;
`endif

  assign push   = (state == IFQ_WAIT) && mem.mem_ack && !redirect && !bypass_take;
  assign pop    = !empty && !stall && !redirect;
  assign wentry = '{pc: fetch_pc, inst: mem.mem_rdata};

  // Room looks at next cycle's occupancy; a redirect flushes, so it always leaves room.
  always_comb begin
    if (redirect) count_n = '0;
    else          count_n = {1'b0, count} + CW1'(push) - CW1'(pop);
    room = (count_n < DEPTH_W);
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    redir_pc_n = redir_pc;
    case (state)
      IFQ_IDLE: begin
        if (redirect)  fetch_pc_n = redirect_pc;
        else if (room) state_n    = IFQ_WAIT;
      end
      IFQ_WAIT: begin
        if (redirect) begin
          if (mem.mem_ack) begin
            fetch_pc_n = redirect_pc;
          end else begin
            redir_pc_n = redirect_pc;
            state_n    = IFQ_DISCARD;
          end
        end else if (mem.mem_ack) begin
          fetch_pc_n = fetch_pc + PC_STEP;
          if (!room) state_n = IFQ_IDLE;
        end
      end
      IFQ_DISCARD: begin
        if (redirect) redir_pc_n = redirect_pc;
        if (mem.mem_ack) begin
          fetch_pc_n = redirect ? redirect_pc : redir_pc;
          state_n    = IFQ_WAIT;
        end
      end
      default: state_n = IFQ_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Clrn) begin
    if (!Clrn) begin
      state    <= IFQ_IDLE;
      fetch_pc <= RESET_PC;
      redir_pc <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      redir_pc <= redir_pc_n;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (Clrn),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_comb begin
    I_Valid = !empty;
    I_PC    = empty ? fetch_pc : head.pc;
    I_Inst  = empty ? NOP_INST : head.inst;
`ifdef IFQ_BYPASS_EN
    if (bypass) begin
      I_Valid = 1'b1;
      I_PC    = fetch_pc;
      I_Inst  = mem.mem_rdata;
    end
`endif
    I_PC4 = I_PC + PC_STEP;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (default build) with a hand-sequenced memory model.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn, clrn2, ack, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] i_pc, i_pc4, i_inst;
  logic        i_valid;
  logic [31:0] i_pc_b, i_pc4_b, i_inst_b;
  logic        i_valid_b;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  inst_fetch_queue_if bus ();
  inst_fetch_queue_if bus2 ();

  assign bus.mem_ack    = ack;
  assign bus.mem_rdata  = inst_of(bus.mem_addr);
  assign bus2.mem_ack   = 1'b1;
  assign bus2.mem_rdata = inst_of(bus2.mem_addr);

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .Clrn(clrn), .mem(bus), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .I_PC(i_pc), .I_PC4(i_pc4), .I_Inst(i_inst), .I_Valid(i_valid)
  );

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .CLK(clk), .Clrn(clrn2), .mem(bus2), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .I_PC(i_pc_b), .I_PC4(i_pc4_b), .I_Inst(i_inst_b), .I_Valid(i_valid_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack_v, input logic stall_v);
    clrn = 1'b0; ack = ack_v; stall = stall_v; redirect = 1'b0; redirect_pc = '0;
    tick();
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; ack = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #3;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
    total++; if (i_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", i_valid); end
    total++; if (i_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", i_inst); end
    total++; if (i_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", i_pc); end
    total++; if (i_pc4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=4", i_pc4); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset(1'b1, 1'b0);
    tick();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL stream_first req=%b addr=%h exp req=1 addr=0", bus.mem_req, bus.mem_addr); end
    total++; if (i_valid !== 1'b0) begin bad++; $display("FAIL stream_prevalid got=%b exp=0", i_valid); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = 32'(4 * k);
      total++; if (bus.mem_addr !== e) begin bad++; $display("FAIL stream_addr%0d got=%h exp=%h", k, bus.mem_addr, e); end
      e = 32'(4 * (k - 1));
      total++; if (i_valid !== 1'b1 || i_pc !== e || i_pc4 !== e + 32'd4 || i_inst !== inst_of(e))
        begin bad++; $display("FAIL stream_head%0d valid=%b pc=%h pc4=%h inst=%h exp pc=%h", k, i_valid, i_pc, i_pc4, i_inst, e); end
    end
  endtask

  task automatic test_stall_fill();
    logic [31:0] e;
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL fill_req got=%b exp=0", bus.mem_req); end
    total++; if (bus.mem_addr !== 32'h10) begin bad++; $display("FAIL fill_pushes addr=%h exp=10", bus.mem_addr); end
    total++; if (i_valid !== 1'b1 || i_pc !== 32'h0) begin bad++; $display("FAIL fill_hold valid=%b pc=%h exp pc=0", i_valid, i_pc); end
    stall = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = 32'(4 * k);
      total++; if (i_valid !== 1'b1 || i_pc !== e || i_inst !== inst_of(e))
        begin bad++; $display("FAIL drain%0d valid=%b pc=%h inst=%h exp pc=%h", k, i_valid, i_pc, i_inst, e); end
    end
  endtask

  task automatic test_redirect_discard();
    do_reset(1'b1, 1'b1);
    tick(); tick(); tick();
    ack = 1'b0;
    tick();
    total++; if (bus.mem_addr !== 32'h8 || i_valid !== 1'b1) begin bad++; $display("FAIL disc_setup addr=%h valid=%b exp addr=8 valid=1", bus.mem_addr, i_valid); end
    redirect = 1'b1; redirect_pc = 32'h100; stall = 1'b0;
    tick();
    redirect = 1'b0; redirect_pc = 32'h0;
    total++; if (i_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8)
      begin bad++; $display("FAIL disc_enter valid=%b req=%b addr=%h exp 0/1/8", i_valid, bus.mem_req, bus.mem_addr); end
    tick();
    total++; if (bus.mem_addr !== 32'h8 || i_valid !== 1'b0) begin bad++; $display("FAIL disc_hold addr=%h valid=%b exp addr=8 valid=0", bus.mem_addr, i_valid); end
    ack = 1'b1;
    tick();
    total++; if (bus.mem_addr !== 32'h100 || i_valid !== 1'b0) begin bad++; $display("FAIL disc_drop addr=%h valid=%b exp addr=100 valid=0", bus.mem_addr, i_valid); end
    tick();
    total++; if (i_valid !== 1'b1 || i_pc !== 32'h100 || i_inst !== inst_of(32'h100))
      begin bad++; $display("FAIL disc_target valid=%b pc=%h inst=%h exp pc=100", i_valid, i_pc, i_inst); end
  endtask

  task automatic test_redirect_on_ack();
    do_reset(1'b1, 1'b0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; redirect_pc = 32'h0;
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || i_valid !== 1'b0)
      begin bad++; $display("FAIL rack_addr req=%b addr=%h valid=%b exp 1/200/0", bus.mem_req, bus.mem_addr, i_valid); end
    tick();
    total++; if (i_valid !== 1'b1 || i_pc !== 32'h200 || bus.mem_addr !== 32'h204)
      begin bad++; $display("FAIL rack_head valid=%b pc=%h addr=%h exp pc=200 addr=204", i_valid, i_pc, bus.mem_addr); end
  endtask

  task automatic test_redirect_stall();
    do_reset(1'b1, 1'b1);
    tick(); tick(); tick(); tick();
    total++; if (i_pc !== 32'h0 || bus.mem_addr !== 32'hC) begin bad++; $display("FAIL rst3_setup pc=%h addr=%h exp pc=0 addr=c", i_pc, bus.mem_addr); end
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    total++; if (i_valid !== 1'b0 || i_pc !== 32'h300 || bus.mem_addr !== 32'h300)
      begin bad++; $display("FAIL rst3_flush valid=%b pc=%h addr=%h exp 0/300/300", i_valid, i_pc, bus.mem_addr); end
    tick();
    total++; if (i_valid !== 1'b1 || i_pc !== 32'h300 || i_pc4 !== 32'h304)
      begin bad++; $display("FAIL rst3_next valid=%b pc=%h pc4=%h exp pc=300 pc4=304", i_valid, i_pc, i_pc4); end
  endtask

  task automatic test_wrap_and_async_reset();
    clrn2 = 1'b1;
    tick();
    total++; if (bus2.mem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_a0 got=%h exp=fffffff8", bus2.mem_addr); end
    tick();
    total++; if (bus2.mem_addr !== 32'hFFFF_FFFC || i_pc_b !== 32'hFFFF_FFF8)
      begin bad++; $display("FAIL wrap_a1 addr=%h pc=%h exp fffffffc/fffffff8", bus2.mem_addr, i_pc_b); end
    tick();
    total++; if (bus2.mem_addr !== 32'h0 || i_pc_b !== 32'hFFFF_FFFC || i_pc4_b !== 32'h0)
      begin bad++; $display("FAIL wrap_a2 addr=%h pc=%h pc4=%h exp 0/fffffffc/0", bus2.mem_addr, i_pc_b, i_pc4_b); end
    #2;
    clrn2 = 1'b0;
    #1;
    total++; if (bus2.mem_req !== 1'b0 || i_valid_b !== 1'b0)
      begin bad++; $display("FAIL async_rst req=%b valid=%b exp 0/0", bus2.mem_req, i_valid_b); end
    total++; if (i_pc_b !== 32'hFFFF_FFF8 || i_pc4_b !== 32'hFFFF_FFFC)
      begin bad++; $display("FAIL async_rst_pc pc=%h pc4=%h exp fffffff8/fffffffc", i_pc_b, i_pc4_b); end
  endtask

  initial begin
    clrn2 = 1'b0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect_discard();
    test_redirect_on_ack();
    test_redirect_stall();
    test_wrap_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Upstream fetch stage for the 5-stage pipelined CPU. It replaces the direct PC-register/InstROM path with a prefetching unit. The unit:
- issues word fetches to a variable-latency instruction memory over a req/ack handshake;
- buffers returned instructions with their PCs in a small FIFO;
- presents the head entry to the IF/ID register;
- honours the load-use stall and the branch/jump redirect coming back from the MEM stage.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
CLK  in  1  clock, rising edge
Clrn  in  1  asynchronous active-low reset
mem_req  out  1  fetch request valid
mem_addr  out  32  fetch word address; stable while mem_req=1 and mem_ack=0
mem_ack  in  1  memory completes the current request this cycle
mem_rdata  in  32  instruction word; valid when mem_ack=1
stall  in  1  load-use stall; hold the head entry
redirect  in  1  taken branch/jump (PCsrc)
redirect_pc  in  32  redirect target
I_PC  out  32  PC of the presented instruction
I_PC4  out  32  I_PC+4, modulo 2^32
I_Inst  out  32  presented instruction
I_Valid  out  1  head entry valid

Behaviour:
- Reset (async, Clrn=0):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty;
  - mem_req=0, I_Valid=0, I_Inst=0, I_PC=RESET_PC, I_PC4=RESET_PC+4.
  - Reset during an outstanding request abandons it; mem_req falls immediately.
- States:
  - IDLE: no request.
  - WAIT: request outstanding.
  - DISCARD: request outstanding whose data must be dropped.
- mem_req = (state != IDLE), combinational. mem_addr = fetch_pc.
- Room rule: room = (count + push - pop) < DEPTH, evaluated for the next cycle.
- IDLE -> WAIT: when room and no redirect.
- WAIT:
  - On mem_ack: push {fetch_pc, mem_rdata} and set fetch_pc += 4.
  - Stay in WAIT if room, otherwise go to IDLE. This gives back-to-back fetches at 1 instruction/cycle with zero-wait memory.
- WAIT with redirect:
  - With no ack this cycle: go to DISCARD.
  - With an ack this cycle: drop the data, set fetch_pc=redirect_pc, stay WAIT (mem_addr=redirect_pc next cycle).
- DISCARD:
  - Keep mem_req high at the old address.
  - On ack: drop the data and go to WAIT with fetch_pc=redirect_pc, which was latched at redirect.
  - A further redirect while in DISCARD only updates the latched target.
- Consumer side:
  - Head entry drives I_PC/I_Inst; I_Valid = !empty.
  - Pop when I_Valid && !stall && !redirect.
  - When empty: I_Inst=32'h0 (NOP), I_PC=fetch_pc.
- Redirect priority: redirect > stall > push/pop.
  - Redirect flushes all FIFO entries in the same edge.
  - I_Valid=0 in the cycle after a redirect.
- Simultaneous push and pop: count is unchanged.
- FIFO never overflows, because at most one request is outstanding and issue is gated by room.
- Pointers wrap modulo DEPTH. fetch_pc and I_PC4 wrap modulo 2^32.
- Latency: mem_ack at edge n -> I_Valid=1 after edge n (one cycle from ack to presentation).

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the FIFO is empty, state=WAIT, mem_ack=1 and redirect=0, the ack data and fetch_pc drive I_Inst/I_PC combinationally with I_Valid=1.
  - If not stalled, the entry is consumed without a push.
  - If stalled, it is pushed normally.
  - Saves one cycle of ack->use latency.
- Undefined: all data passes through the FIFO; I_Valid is purely registered.

Decomposition:
- Shared package holds:
  - NOP_INST = 32'h0;
  - PC_STEP = 32'd4;
  - state encoding IFQ_IDLE=2'd0, IFQ_WAIT=2'd1, IFQ_DISCARD=2'd2.
- One sub-module: ifq_fifo.
  - Parameterised DEPTH x 64-bit storage with head/tail pointers, count, push, pop and flush.
  - Flush takes priority over push/pop.

Test Plan:
1. Reset release, mem_ack tied 1, RESET_PC=0 -> mem_addr 0,4,8,12 on consecutive cycles; I_Valid=1 from the cycle after the first ack; I_PC 0,4,8 in order; I_PC4=I_PC+4.
2. stall=1 for 10 cycles, ack always 1, DEPTH=4 -> exactly 4 pushes, then mem_req=0 and I_PC held at 0. Release stall -> I_PC 0,4,8,12,16,... with no loss or duplicate.
3. ack delayed 3 cycles; redirect=1 with redirect_pc=0x100 while in WAIT at address 0x8 -> next cycle I_Valid=0 and state DISCARD with mem_addr=0x8. The ack data is dropped. Next mem_addr=0x100, then I_PC=0x100.
4. redirect to 0x200 in the same cycle as mem_ack -> data not pushed, mem_addr=0x200 next cycle, DISCARD never entered.
5. redirect and stall asserted together with 3 entries buffered -> FIFO empty after the edge; next valid I_PC=redirect_pc.
6. RESET_PC=0xFFFF_FFF8, zero-wait memory -> mem_addr F8, FC, 0x0; I_PC4 for PC 0xFFFF_FFFC is 0x0. Then assert Clrn=0 mid-WAIT -> mem_req=0 and I_Valid=0 immediately.
